pe_seq_ctrl: RTL

PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

---
 rtl/pe_seq_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pe_seq_ctrl.sv
// Job sequencer for a 3-tap PE: issues ifm/weight reads per group, accumulates PE partial sums, hands out one ofm per pixel.
// Optional build macro PE_SEQ_CTRL_RELU_EN clamps negative results to zero on ofm_data.
module pe_seq_ctrl #(
  parameter int PIPE_LAT = 4,
  parameter int ADDR_W   = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           cfg_groups,
  input  logic [9:0]           cfg_pixels,
  output logic [ADDR_W-1:0]    ifm_addr,
  output logic [3:0]           wgt_addr,
  output logic                 rd_en,
  input  logic signed [31:0]   pe_p_sum,
  output logic signed [31:0]   ofm_data,
  output logic                 ofm_valid,
  input  logic                 ofm_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [PIPE_LAT-1:0] LAST_MASK = PIPE_LAT'(1) << (PIPE_LAT - 1);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_groups;
  logic [9:0]            r_pixels;
  logic [ADDR_W-1:0]     r_addr;
  logic [3:0]            r_g;
  logic [9:0]            r_p;
  logic signed [31:0]    r_acc;
  logic [PIPE_LAT-1:0]   r_vld;

  logic                  w_issue;
  logic                  w_out;
  logic                  w_hs;
  logic                  w_last_g;
  logic                  w_last_p;
  logic                  w_pending;
  logic                  w_accept;

  function automatic logic signed [31:0] relu_fn(input logic signed [31:0] a);
`ifdef PE_SEQ_CTRL_RELU_EN
    return (a < 0) ? 32'sd0 : a;
`else
    return a;
`endif
  endfunction

  assign w_issue   = (r_state == S_ISSUE);
  assign w_out     = (r_state == S_OUT);
  assign w_hs      = w_out && ofm_ready;
  assign w_last_g  = (r_g == r_groups - 4'd1);
  assign w_last_p  = (r_p == r_pixels - 10'd1);
  assign w_accept  = (r_state == S_IDLE) && start;
  // Only the final in-flight sum may still be outstanding when leaving DRAIN; it lands on that same edge.
  assign w_pending = |(r_vld & ~LAST_MASK);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((cfg_groups == 4'd0) || (cfg_pixels == 10'd0)) w_next = S_DONE;
          else                                               w_next = S_ISSUE;
        end
      end
      S_ISSUE: if (w_last_g)   w_next = S_DRAIN;
      S_DRAIN: if (!w_pending) w_next = S_OUT;
      S_OUT: begin
        if (ofm_ready) w_next = w_last_p ? S_DONE : S_ISSUE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_groups <= '0;
      r_pixels <= '0;
      r_addr   <= '0;
      r_g      <= '0;
      r_p      <= '0;
      r_acc    <= '0;
      r_vld    <= '0;
    end else begin
      r_state <= w_next;
      r_vld   <= (r_vld << 1) | PIPE_LAT'(w_issue);
      if (r_vld[PIPE_LAT-1]) r_acc <= r_acc + pe_p_sum;
      if (w_accept) begin
        r_groups <= cfg_groups;
        r_pixels <= cfg_pixels;
        r_addr   <= '0;
        r_g      <= '0;
        r_p      <= '0;
        r_acc    <= '0;
      end
      if (w_issue) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_g    <= r_g + 4'd1;
      end
      // Next pixel keeps the ifm address running; only group index and sum restart.
      if (w_hs && !w_last_p) begin
        r_p   <= r_p + 10'd1;
        r_g   <= '0;
        r_acc <= '0;
      end
    end
  end

  assign rd_en     = w_issue;
  assign ifm_addr  = w_issue ? r_addr : '0;
  assign wgt_addr  = w_issue ? r_g : '0;
  assign ofm_valid = w_out;
  assign ofm_data  = w_out ? relu_fn(r_acc) : 32'sd0;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule
